// File: rtl/pipe_ex_driver_if.sv
// Operand/result bus between the driver and the pipe_ex_ arithmetic pipeline.
interface pipe_ex_driver_if #(
  parameter int N = 10
);
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] c;
  logic [N-1:0] d;
  logic [N-1:0] f;

  modport master (output a, b, c, d, input f);
  modport slave  (input a, b, c, d, output f);
endinterface

// File: rtl/pipe_ex_driver.sv
// Issues a programmed run of operand vectors into the pipe_ex_ pipeline and
// checks each returned f against an expected value carried in a delay line.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | driving one vector per clock
// DRAIN | no new vectors, waiting for in-flight results
// DONE  | one-cycle done pulse
module pipe_ex_driver #(
  parameter int N       = 10,
  parameter int LAT     = 4,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_vec,
  input  logic [N-1:0]       seed,
  pipe_ex_driver_if.master   bus,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] pass_cnt,
  output logic [COUNT_W-1:0] err_cnt,
  output logic [COUNT_W-1:0] first_err_idx
);

  localparam int TW = $clog2(LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [TW-1:0]      r_tmr;
  logic [COUNT_W-1:0] r_k;
  logic [COUNT_W-1:0] r_nv;
  logic [N-1:0]       r_seed;
  logic [N-1:0]       r_a, r_b, r_c, r_d;

  logic               r_dl_vld [LAT];
  logic [COUNT_W-1:0] r_dl_idx [LAT];
  logic [N-1:0]       r_dl_exp [LAT];

  logic               w_accept;
  logic               w_issue;
  logic               w_last;
  logic [COUNT_W-1:0] w_k;
  logic [COUNT_W-1:0] w_nv;
  logic [N-1:0]       w_seed;
  logic [N-1:0]       w_kn;
  logic [N-1:0]       w_a, w_b, w_c, w_d, w_exp;
  logic               w_cmp;
  logic               w_match;

  // Vector 0 is issued on the accepting edge itself, so IDLE feeds the issue path
  assign w_accept = (r_state == S_IDLE) && start;
  assign w_issue  = (w_accept && (num_vec != '0)) || (r_state == S_ISSUE);
  assign w_k      = (r_state == S_ISSUE) ? r_k    : '0;
  assign w_nv     = (r_state == S_ISSUE) ? r_nv   : num_vec;
  assign w_seed   = (r_state == S_ISSUE) ? r_seed : seed;
  assign w_last   = w_issue && (w_k == (w_nv - 1'b1));

  assign w_kn  = N'(w_k);
  assign w_a   = w_seed + w_kn;
  assign w_b   = w_kn + (w_kn << 1);
  assign w_c   = w_seed - w_kn;
  assign w_d   = w_kn << 1;
  assign w_exp = w_a + w_b + w_c;

  assign w_cmp   = r_dl_vld[LAT-1];
  assign w_match = (bus.f == r_dl_exp[LAT-1]);

  assign bus.a = r_a;
  assign bus.b = r_b;
  assign bus.c = r_c;
  assign bus.d = r_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (num_vec == '0) w_state_nxt = S_DONE;
          else if (w_last)   w_state_nxt = S_DRAIN;
          else               w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: if (w_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_tmr == '0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_ISSUE, S_DRAIN: busy = 1'b1;
      S_DONE:           done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= '0;
      r_d    <= '0;
      r_seed <= '0;
      r_nv   <= '0;
      r_k    <= '0;
      r_tmr  <= '0;
    end else begin
      r_a <= w_issue ? w_a : '0;
      r_b <= w_issue ? w_b : '0;
      r_c <= w_issue ? w_c : '0;
      r_d <= w_issue ? w_d : '0;
      if (w_accept) begin
        r_seed <= seed;
        r_nv   <= num_vec;
        r_k    <= COUNT_W'(1);
      end else if (r_state == S_ISSUE) begin
        r_k <= r_k + 1'b1;
      end
      // DRAIN lasts one cycle beyond the last compare
      if (w_last)                                   r_tmr <= TW'(LAT);
      else if ((r_state == S_DRAIN) && (r_tmr != '0)) r_tmr <= r_tmr - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        r_dl_vld[i] <= 1'b0;
        r_dl_idx[i] <= '0;
        r_dl_exp[i] <= '0;
      end
    end else begin
      r_dl_vld[0] <= w_issue;
      r_dl_idx[0] <= w_k;
      r_dl_exp[0] <= w_exp;
      for (int i = 1; i < LAT; i++) begin
        r_dl_vld[i] <= r_dl_vld[i-1];
        r_dl_idx[i] <= r_dl_idx[i-1];
        r_dl_exp[i] <= r_dl_exp[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt      <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
    end else if (w_accept) begin
      pass_cnt      <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
    end else if (w_cmp) begin
      if (w_match) begin
        if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
      end else begin
        if (err_cnt == '0) first_err_idx <= r_dl_idx[LAT-1];
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule
